apb_modport: RTL and testbench

- APB3 slave register block for the UART: programs line control and baud divisor, and hands TX bytes to the UART core.
- Buffers RX bytes from the core in a small FIFO and reports status/interrupt.
- Sits between the APB fabric (PCLK domain) and the UART TX/RX engines; zero-wait-state slave.

---
 rtl/uart_apb_pkg.sv | 38 +++
 rtl/uart_rx_fifo.sv | 72 +++++++
 rtl/apb_modport.sv | 188 ++++++++++++++++++
 tb/tb_apb_modport.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_apb_pkg.sv
// ============================================================================
// Module : uart_apb_pkg
// Desc   : Register map and bit positions shared by the UART APB register block.
//          The CTRL loopback bit exists only when UART_APB_LOOPBACK_EN is defined.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package uart_apb_pkg;

  // Register index = PADDR[4:2]
  localparam logic [2:0] c_reg_ctrl   = 3'd0;
  localparam logic [2:0] c_reg_baud   = 3'd1;
  localparam logic [2:0] c_reg_txdata = 3'd2;
  localparam logic [2:0] c_reg_rxdata = 3'd3;
  localparam logic [2:0] c_reg_status = 3'd4;

  localparam int c_ctrl_w          = 7;
  localparam int c_ctrl_en         = 0;
  localparam int c_ctrl_par_en     = 1;
  localparam int c_ctrl_par_odd    = 2;
  localparam int c_ctrl_stop2      = 3;
  localparam int c_ctrl_rx_irq_en  = 4;
  localparam int c_ctrl_tx_irq_en  = 5;
`ifdef UART_APB_LOOPBACK_EN
  localparam int c_ctrl_loopback   = 6;
`endif

  localparam int c_stat_tx_full  = 0;
  localparam int c_stat_rx_empty = 1;
  localparam int c_stat_rx_full  = 2;
  localparam int c_stat_overrun  = 3;

  localparam logic [15:0] c_baud_rst = 16'd1;

endpackage

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ============================================================================
// Module : uart_rx_fifo
// Desc   : 8-bit RX byte FIFO; a push while full is dropped unless a pop
//          frees a slot in the same cycle, in which case both take effect.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module uart_rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_pop,
  output logic [7:0] o_data,
  output logic       o_full,
  output logic       o_empty,
  output logic       o_overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full     = (count_q == CNT_W'(DEPTH));
  assign o_empty    = (count_q == '0);
  assign w_do_pop   = i_pop & ~o_empty;
  assign w_do_push  = i_push & (~o_full | w_do_pop);
  assign o_overflow = i_push & o_full & ~w_do_pop;
  assign o_data     = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so pointer increments wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (w_do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({w_do_push, w_do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) mem_q[wr_ptr_q] <= i_data;
  end

endmodule

`default_nettype wire

// File: rtl/apb_modport.sv
// ============================================================================
// Module : apb_modport
// Desc   : Zero-wait-state APB3 register block for a UART: CTRL/BAUD/TXDATA/
//          RXDATA/STATUS. Optional loopback via UART_APB_LOOPBACK_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module apb_modport
  import uart_apb_pkg::*;
#(
  parameter int PADDR_WIDTH   = 8,
  parameter int PDATA_WIDTH   = 32,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  input  logic                   PSEL,
  input  logic                   PENABLE,
  input  logic                   PWRITE,
  input  logic [PADDR_WIDTH-1:0] PADDR,
  input  logic [PDATA_WIDTH-1:0] PWDATA,
  output logic [PDATA_WIDTH-1:0] PRDATA,
  output logic                   PREADY,
  output logic                   PSLVERR,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   uart_en,
  output logic                   parity_en,
  output logic                   parity_odd,
  output logic                   stop2,
  output logic [15:0]            baud_div,
  output logic                   irq
);

`ifdef UART_APB_LOOPBACK_EN
  localparam logic [c_ctrl_w-1:0] c_ctrl_mask = 7'h7F;
`else
  localparam logic [c_ctrl_w-1:0] c_ctrl_mask = 7'h3F;
`endif

  logic [c_ctrl_w-1:0]    ctrl_q, ctrl_d;
  logic [15:0]            baud_q, baud_d;
  logic [7:0]             tx_hold_q, tx_hold_d;
  logic                   tx_full_q, tx_full_d;
  logic                   overrun_q, overrun_d;
  logic [PDATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                   pslverr_q, pslverr_d;

  logic [PDATA_WIDTH-1:0] w_rd_val;
  logic [2:0]             w_idx;
  logic                   w_setup, w_wr_acc, w_rd_acc, w_bad, w_setup_err;
  logic                   w_tx_valid, w_tx_drain, w_tx_load;
  logic                   w_fifo_push, w_fifo_pop;
  logic [7:0]             w_fifo_wdata, w_rx_head;
  logic                   w_rx_full, w_rx_empty, w_rx_ovf;
  logic                   w_unused;

  assign w_idx    = PADDR[4:2];
  assign w_setup  = PSEL & ~PENABLE;
  assign w_wr_acc = PSEL & PENABLE & PWRITE;
  assign w_rd_acc = PSEL & PENABLE & ~PWRITE;
  assign w_bad    = (w_idx > c_reg_status);
  assign w_unused = ^{PADDR, PWDATA};

  // Errors are judged at the setup edge so PSLVERR is valid through access.
  assign w_setup_err = w_bad
                     | (~PWRITE & (w_idx == c_reg_rxdata) & w_rx_empty)
                     | ( PWRITE & (w_idx == c_reg_txdata) & tx_full_q);

`ifdef UART_APB_LOOPBACK_EN
  logic w_lb;
  logic w_lb_push;
  assign w_lb         = ctrl_q[c_ctrl_loopback];
  assign w_lb_push    = w_lb & tx_full_q;
  assign w_tx_valid   = tx_full_q & ~w_lb;
  assign w_tx_drain   = (w_tx_valid & tx_ready) | w_lb_push;
  assign w_fifo_push  = w_lb ? w_lb_push : rx_valid;
  assign w_fifo_wdata = w_lb ? tx_hold_q : rx_data;
`else
  assign w_tx_valid   = tx_full_q;
  assign w_tx_drain   = tx_full_q & tx_ready;
  assign w_fifo_push  = rx_valid;
  assign w_fifo_wdata = rx_data;
`endif

  // A pop only happens when the setup phase actually returned a byte.
  assign w_fifo_pop = w_rd_acc & (w_idx == c_reg_rxdata) & ~w_rx_empty & ~pslverr_q;
  assign w_tx_load  = w_wr_acc & (w_idx == c_reg_txdata) & ~tx_full_q;

  uart_rx_fifo #(
    .DEPTH (RX_FIFO_DEPTH)
  ) u_rx_fifo (
    .clk        (PCLK),
    .rst        (PRESET),
    .i_push     (w_fifo_push),
    .i_data     (w_fifo_wdata),
    .i_pop      (w_fifo_pop),
    .o_data     (w_rx_head),
    .o_full     (w_rx_full),
    .o_empty    (w_rx_empty),
    .o_overflow (w_rx_ovf)
  );

  always_comb begin
    w_rd_val = '0;
    case (w_idx)
      c_reg_ctrl:   w_rd_val[c_ctrl_w-1:0] = ctrl_q;
      c_reg_baud:   w_rd_val[15:0]         = baud_q;
      c_reg_rxdata: if (!w_rx_empty) w_rd_val[7:0] = w_rx_head;
      c_reg_status: begin
        w_rd_val[c_stat_tx_full]  = tx_full_q;
        w_rd_val[c_stat_rx_empty] = w_rx_empty;
        w_rd_val[c_stat_rx_full]  = w_rx_full;
        w_rd_val[c_stat_overrun]  = overrun_q;
      end
      default: w_rd_val = '0;
    endcase
  end

  always_comb begin
    ctrl_d    = ctrl_q;
    baud_d    = baud_q;
    tx_hold_d = tx_hold_q;
    tx_full_d = tx_full_q;
    overrun_d = overrun_q;
    prdata_d  = prdata_q;
    pslverr_d = pslverr_q;

    if (w_setup) begin
      pslverr_d = w_setup_err;
      if (!PWRITE) prdata_d = w_rd_val;
    end

    if (w_wr_acc && w_idx == c_reg_ctrl) ctrl_d = PWDATA[c_ctrl_w-1:0] & c_ctrl_mask;
    if (w_wr_acc && w_idx == c_reg_baud) baud_d = PWDATA[15:0];

    if (w_tx_load) begin
      tx_hold_d = PWDATA[7:0];
      tx_full_d = 1'b1;
    end else if (w_tx_drain) begin
      tx_full_d = 1'b0;
    end

    // A new overflow wins over a same-cycle write-1-to-clear.
    if (w_wr_acc && w_idx == c_reg_status && PWDATA[c_stat_overrun]) overrun_d = 1'b0;
    if (w_rx_ovf) overrun_d = 1'b1;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      ctrl_q    <= '0;
      baud_q    <= c_baud_rst;
      tx_hold_q <= '0;
      tx_full_q <= 1'b0;
      overrun_q <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      baud_q    <= baud_d;
      tx_hold_q <= tx_hold_d;
      tx_full_q <= tx_full_d;
      overrun_q <= overrun_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
    end
  end

  assign PRDATA     = prdata_q;
  assign PSLVERR    = pslverr_q;
  assign PREADY     = 1'b1;
  assign tx_data    = tx_hold_q;
  assign tx_valid   = w_tx_valid;
  assign uart_en    = ctrl_q[c_ctrl_en];
  assign parity_en  = ctrl_q[c_ctrl_par_en];
  assign parity_odd = ctrl_q[c_ctrl_par_odd];
  assign stop2      = ctrl_q[c_ctrl_stop2];
  assign baud_div   = baud_q;
  assign irq        = (ctrl_q[c_ctrl_rx_irq_en] & ~w_rx_empty)
                    | (ctrl_q[c_ctrl_tx_irq_en] & ~tx_full_q);

endmodule

`default_nettype wire

// File: tb/tb_apb_modport.sv
// ============================================================================
// Module : tb_apb_modport
// Desc   : Self-checking bench for apb_modport: register vector table plus
//          hand-written TX/RX/reset sequences, reads checked via a scoreboard.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_apb_modport;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [7:0]  PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        uart_en, parity_en, parity_odd, stop2;
  logic [15:0] baud_div;
  logic        irq;

  apb_modport #(
    .PADDR_WIDTH   (8),
    .PDATA_WIDTH   (32),
    .RX_FIFO_DEPTH (4)
  ) dut (
    .PCLK       (PCLK),
    .PRESET     (PRESET),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PWRITE     (PWRITE),
    .PADDR      (PADDR),
    .PWDATA     (PWDATA),
    .PRDATA     (PRDATA),
    .PREADY     (PREADY),
    .PSLVERR    (PSLVERR),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .uart_en    (uart_en),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .stop2      (stop2),
    .baud_div   (baud_div),
    .irq        (irq)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  typedef struct packed {
    logic        wr;
    logic [31:0] data;
    logic        err;
  } exp_t;

  localparam int NV = 13;
  vec_t        tbl [NV];
  exp_t        sb [$];
  logic [7:0]  rxm [$];
  logic        ovr_m = 1'b0;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // One APB transfer; optional tx_ready / rx_valid stimulus during the access phase.
  task automatic apb(input logic wr, input logic [7:0] a, input logic [31:0] wd,
                     input logic ardy, input logic apush, input logic [7:0] ab,
                     output logic [31:0] rd, output logic err);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = wd;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    if (ardy) tx_ready = 1'b1;
    if (apush) begin rx_valid = 1'b1; rx_data = ab; end
    rd  = PRDATA;
    err = PSLVERR;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; rx_valid = 1'b0;
    if (ardy) tx_ready = 1'b0;
  endtask

  task automatic do_xfer(input string nm, input logic wr, input logic [7:0] a,
                         input logic [31:0] wd, input logic [31:0] ed, input logic ee,
                         input logic ardy, input logic apush, input logic [7:0] ab);
    logic [31:0] rd;
    logic        err;
    exp_t        e;
    sb.push_back('{wr: wr, data: ed, err: ee});
    apb(wr, a, wd, ardy, apush, ab, rd, err);
    if (sb.size() == 0) begin
      chk({nm, "_sb"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      if (!e.wr) chk({nm, "_data"}, rd, e.data);
      chk({nm, "_err"}, {31'd0, err}, {31'd0, e.err});
    end
  endtask

  task automatic model_push(input logic [7:0] b);
    if (rxm.size() < 4) rxm.push_back(b);
    else ovr_m = 1'b1;
  endtask

  task automatic rx_strobe(input logic [7:0] b);
    @(posedge PCLK); #1;
    rx_valid = 1'b1; rx_data = b;
    @(posedge PCLK); #1;
    rx_valid = 1'b0;
    model_push(b);
  endtask

  task automatic rx_read(input string nm, input logic apush, input logic [7:0] ab);
    logic [31:0] ed;
    logic        ee;
    if (rxm.size() == 0) begin ed = 32'd0; ee = 1'b1; end
    else begin ed = {24'd0, rxm.pop_front()}; ee = 1'b0; end
    do_xfer(nm, 1'b0, 8'h0C, 32'd0, ed, ee, 1'b0, apush, ab);
    if (apush) model_push(ab);
  endtask

  function automatic logic [31:0] rx_stat();
    return {28'd0, ovr_m, rxm.size() == 4, rxm.size() == 0, 1'b0};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected test end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0]  = '{1'b0, 8'h00, 32'h0,    32'h0,    1'b0};
    tbl[1]  = '{1'b0, 8'h04, 32'h0,    32'h1,    1'b0};
    tbl[2]  = '{1'b0, 8'h08, 32'h0,    32'h0,    1'b0};
    tbl[3]  = '{1'b0, 8'h0C, 32'h0,    32'h0,    1'b1};
    tbl[4]  = '{1'b0, 8'h10, 32'h0,    32'h2,    1'b0};
    tbl[5]  = '{1'b0, 8'h14, 32'h0,    32'h0,    1'b1};
    tbl[6]  = '{1'b1, 8'h04, 32'h1234, 32'h0,    1'b0};
    tbl[7]  = '{1'b1, 8'h00, 32'hFF,   32'h0,    1'b0};
    tbl[8]  = '{1'b0, 8'h00, 32'h0,    32'h3F,   1'b0};
    tbl[9]  = '{1'b0, 8'h05, 32'h0,    32'h1234, 1'b0};
    tbl[10] = '{1'b1, 8'h1C, 32'hFFFF, 32'h0,    1'b1};
    tbl[11] = '{1'b0, 8'h1C, 32'h0,    32'h0,    1'b1};
    tbl[12] = '{1'b0, 8'h13, 32'h0,    32'h2,    1'b0};

    repeat (2) @(posedge PCLK);
    #1 PRESET = 1'b0;
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_irq",      {31'd0, irq},      32'd0);
    chk("rst_prdata",   PRDATA,            32'd0);
    chk("rst_pslverr",  {31'd0, PSLVERR},  32'd0);
    chk("rst_baud",     {16'd0, baud_div}, 32'd1);
    chk("rst_pready",   {31'd0, PREADY},   32'd1);

    for (int i = 0; i < NV; i++)
      do_xfer($sformatf("vec%0d", i), tbl[i].wr, tbl[i].addr, tbl[i].wdata,
              tbl[i].exp_data, tbl[i].exp_err, 1'b0, 1'b0, 8'h00);
    chk("baud_div", {16'd0, baud_div}, 32'h1234);
    chk("ctrl_pins", {28'd0, stop2, parity_odd, parity_en, uart_en}, 32'hF);
    chk("irq_tx_empty", {31'd0, irq}, 32'd1);

    // TX holding register
    do_xfer("tx_a5", 1'b1, 8'h08, 32'hA5, 32'd0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("tx_valid_a5", {31'd0, tx_valid}, 32'd1);
    chk("tx_data_a5",  {24'd0, tx_data},  32'hA5);
    chk("irq_tx_full", {31'd0, irq},      32'd0);
    do_xfer("tx_5a_full", 1'b1, 8'h08, 32'h5A, 32'd0, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("tx_data_held", {24'd0, tx_data}, 32'hA5);
    do_xfer("stat_txfull", 1'b0, 8'h10, 32'd0, 32'h3, 1'b0, 1'b0, 1'b0, 8'h00);
    @(posedge PCLK); #1 tx_ready = 1'b1;
    @(posedge PCLK); #1 tx_ready = 1'b0;
    chk("tx_valid_drained", {31'd0, tx_valid}, 32'd0);
    do_xfer("stat_txempty", 1'b0, 8'h10, 32'd0, 32'h2, 1'b0, 1'b0, 1'b0, 8'h00);
    do_xfer("tx_11", 1'b1, 8'h08, 32'h11, 32'd0, 1'b0, 1'b0, 1'b0, 8'h00);
    do_xfer("tx_drain_same", 1'b1, 8'h08, 32'h22, 32'd0, 1'b1, 1'b1, 1'b0, 8'h00);
    chk("tx_valid_after_drop", {31'd0, tx_valid}, 32'd0);

    // RX FIFO overrun and drain
    for (int b = 1; b <= 5; b++) rx_strobe(8'(b));
    do_xfer("stat_ovr", 1'b0, 8'h10, 32'd0, rx_stat(), 1'b0, 1'b0, 1'b0, 8'h00);
    chk("irq_rx", {31'd0, irq}, 32'd1);
    for (int k = 0; k < 5; k++) rx_read($sformatf("rx_rd%0d", k), 1'b0, 8'h00);
    do_xfer("w1c_ovr", 1'b1, 8'h10, 32'h8, 32'd0, 1'b0, 1'b0, 1'b0, 8'h00);
    ovr_m = 1'b0;
    do_xfer("stat_clr", 1'b0, 8'h10, 32'd0, rx_stat(), 1'b0, 1'b0, 1'b0, 8'h00);
    do_xfer("rd_18", 1'b0, 8'h18, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 8'h00);

    // Pop and push together while full: no overrun
    for (int b = 16; b < 20; b++) rx_strobe(8'(b));
    rx_read("rx_poppush", 1'b1, 8'h14);
    do_xfer("stat_poppush", 1'b0, 8'h10, 32'd0, rx_stat(), 1'b0, 1'b0, 1'b0, 8'h00);
    // W1C in the same cycle as a new overrun keeps it set
    ovr_m = 1'b0;
    do_xfer("w1c_vs_ovr", 1'b1, 8'h10, 32'h8, 32'd0, 1'b0, 1'b0, 1'b1, 8'h15);
    model_push(8'h15);
    do_xfer("stat_ovr_kept", 1'b0, 8'h10, 32'd0, rx_stat(), 1'b0, 1'b0, 1'b0, 8'h00);
    do_xfer("w1c_ovr2", 1'b1, 8'h10, 32'h8, 32'd0, 1'b0, 1'b0, 1'b0, 8'h00);
    ovr_m = 1'b0;
    for (int k = 0; k < 4; k++) rx_read($sformatf("rx_drain%0d", k), 1'b0, 8'h00);
    // Empty read with a simultaneous push keeps the pushed byte
    rx_read("rx_empty_push", 1'b1, 8'h66);
    do_xfer("stat_one", 1'b0, 8'h10, 32'd0, rx_stat(), 1'b0, 1'b0, 1'b0, 8'h00);
    rx_read("rx_66", 1'b0, 8'h00);

    // Reset during a TXDATA access phase
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h08; PWDATA = 32'h99;
    @(posedge PCLK); #1;
    PENABLE = 1'b1; PRESET = 1'b1;
    @(posedge PCLK); #1;
    PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    chk("rstx_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rstx_uart_en",  {31'd0, uart_en},  32'd0);
    chk("rstx_baud",     {16'd0, baud_div}, 32'd1);
    chk("rstx_prdata",   PRDATA,            32'd0);
    rxm.delete();
    ovr_m = 1'b0;
    do_xfer("rstx_stat", 1'b0, 8'h10, 32'd0, rx_stat(), 1'b0, 1'b0, 1'b0, 8'h00);
    do_xfer("rstx_ctrl", 1'b0, 8'h00, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
